// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies a block of words from a source address to a
// destination address over the data-memory request/response protocol.
// Each word is moved as a read followed by a write. Addresses ascend and
// wrap modulo 2^ADDR_W.
//
// Handshake: a request is live whenever the engine is busy (READ or WRITE).
// The request fields are held stable while the responder returns PENDING.
// An OK or FAULT code completes the access at that clock edge. Any other
// code value counts as PENDING.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_CODE_PENDING
`define MEM_CODE_PENDING 2'd0
`endif
`ifndef MEM_CODE_OK
`define MEM_CODE_OK 2'd1
`endif
`ifndef MEM_CODE_FAULT
`define MEM_CODE_FAULT 2'd2
`endif

module mem_copy_engine #(
  parameter int LEN_W      = 16,
  parameter int WORD_BYTES = `WORD_W / 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_start,
  input  logic [`ADDR_W-1:0]      i_src_addr,
  input  logic [`ADDR_W-1:0]      i_dst_addr,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [`ADDR_W-1:0]      o_err_addr,
  output logic [`ADDR_W-1:0]      o_mem_req_addr,
  output logic [`WORD_W-1:0]      o_mem_req_wr_data,
  output logic                    o_mem_req_wr_en,
  output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
  input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_mem_res_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [`ADDR_W-1:0] STEP    = `ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]   LEN_ONE = LEN_W'(1);

  // Current state and registered datapath. The write-data register doubles
  // as the word buffer between the read and the write of each word.
  state_t               state, state_n;
  logic [`ADDR_W-1:0]   src, src_n;
  logic [`ADDR_W-1:0]   dst, dst_n;
  logic [LEN_W-1:0]     remaining, remaining_n;
  logic                 busy_n, done_n, error_n, wr_en_n;
  logic [`ADDR_W-1:0]   err_addr_n, req_addr_n;
  logic [`WORD_W-1:0]   wr_data_n;

  logic resp_ok, resp_fault;
  assign resp_ok    = (i_mem_res_code == `MEM_CODE_OK);
  assign resp_fault = (i_mem_res_code == `MEM_CODE_FAULT);

  // The access size never changes: every access is one full word.
  assign o_mem_req_count = `MEM_COUNT_WORD;

  // State and output registers. Reset aborts any transfer at once.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      src               <= '0;
      dst               <= '0;
      remaining         <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_error           <= 1'b0;
      o_err_addr        <= '0;
      o_mem_req_addr    <= '0;
      o_mem_req_wr_data <= '0;
      o_mem_req_wr_en   <= 1'b0;
    end else begin
      state             <= state_n;
      src               <= src_n;
      dst               <= dst_n;
      remaining         <= remaining_n;
      o_busy            <= busy_n;
      o_done            <= done_n;
      o_error           <= error_n;
      o_err_addr        <= err_addr_n;
      o_mem_req_addr    <= req_addr_n;
      o_mem_req_wr_data <= wr_data_n;
      o_mem_req_wr_en   <= wr_en_n;
    end
  end

  // Next-state and next-output logic. Request fields only change on a
  // transition, so a PENDING response leaves everything as it is.
  always_comb begin
    state_n     = state;
    src_n       = src;
    dst_n       = dst;
    remaining_n = remaining;
    busy_n      = o_busy;
    done_n      = 1'b0;
    error_n     = o_error;
    err_addr_n  = o_err_addr;
    req_addr_n  = o_mem_req_addr;
    wr_data_n   = o_mem_req_wr_data;
    wr_en_n     = o_mem_req_wr_en;

    case (state)
      IDLE: begin
        if (i_start) begin
          src_n       = i_src_addr;
          dst_n       = i_dst_addr;
          remaining_n = i_len;
          error_n     = 1'b0;
          if (i_len == '0) begin
            // Empty copy: complete immediately without touching memory.
            done_n = 1'b1;
          end else begin
            state_n    = READ;
            busy_n     = 1'b1;
            req_addr_n = i_src_addr;
            wr_en_n    = 1'b0;
          end
        end
      end

      READ: begin
        if (resp_ok) begin
          state_n    = WRITE;
          req_addr_n = dst;
          wr_data_n  = i_mem_res_rd_data;
          wr_en_n    = 1'b1;
        end else if (resp_fault) begin
          state_n    = IDLE;
          busy_n     = 1'b0;
          error_n    = 1'b1;
          err_addr_n = src;
          req_addr_n = '0;
          wr_en_n    = 1'b0;
        end
      end

      WRITE: begin
        if (resp_ok) begin
          if (remaining == LEN_ONE) begin
            state_n    = IDLE;
            busy_n     = 1'b0;
            done_n     = 1'b1;
            req_addr_n = '0;
            wr_en_n    = 1'b0;
          end else begin
            state_n     = READ;
            remaining_n = remaining - LEN_ONE;
            src_n       = src + STEP;
            dst_n       = dst + STEP;
            req_addr_n  = src + STEP;
            wr_en_n     = 1'b0;
          end
        end else if (resp_fault) begin
          state_n    = IDLE;
          busy_n     = 1'b0;
          error_n    = 1'b1;
          err_addr_n = dst;
          req_addr_n = '0;
          wr_en_n    = 1'b0;
        end
      end

      default: begin
        state_n    = IDLE;
        busy_n     = 1'b0;
        req_addr_n = '0;
        wr_en_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: a word memory with a programmable stall count
// and fault limit answers the engine. A reference copy model fills the
// expected-write queue, and every completed write is checked against it.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 3'd4
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_CODE_PENDING
`define MEM_CODE_PENDING 2'd0
`endif
`ifndef MEM_CODE_OK
`define MEM_CODE_OK 2'd1
`endif
`ifndef MEM_CODE_FAULT
`define MEM_CODE_FAULT 2'd2
`endif

module tb_mem_copy_engine;

  localparam int BUDGET = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic                    i_start;
  logic [31:0]             i_src_addr, i_dst_addr;
  logic [15:0]             i_len;
  logic                    o_busy, o_done, o_error;
  logic [31:0]             o_err_addr, o_mem_req_addr, o_mem_req_wr_data;
  logic                    o_mem_req_wr_en;
  logic [`MEM_COUNT_W-1:0] o_mem_req_count;
  logic [31:0]             i_mem_res_rd_data;
  logic [`MEM_CODE_W-1:0]  i_mem_res_code;

  mem_copy_engine dut (
    .clk               (clk),
    .resetn            (resetn),
    .i_start           (i_start),
    .i_src_addr        (i_src_addr),
    .i_dst_addr        (i_dst_addr),
    .i_len             (i_len),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_err_addr        (o_err_addr),
    .o_mem_req_addr    (o_mem_req_addr),
    .o_mem_req_wr_data (o_mem_req_wr_data),
    .o_mem_req_wr_en   (o_mem_req_wr_en),
    .o_mem_req_count   (o_mem_req_count),
    .i_mem_res_rd_data (i_mem_res_rd_data),
    .i_mem_res_code    (i_mem_res_code)
  );

  // ---------------- memory responder ----------------
  logic [31:0] mem [0:255];
  logic [31:0] model_mem [0:255];
  int          stall;
  int          wait_left;
  logic [31:0] limit;
  logic        load_en;
  logic [7:0]  load_idx;
  logic [31:0] load_data;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  // Response is combinational from the registered request.
  always_comb begin
    if (wait_left != 0)             i_mem_res_code = `MEM_CODE_PENDING;
    else if (o_mem_req_addr > limit) i_mem_res_code = `MEM_CODE_FAULT;
    else                             i_mem_res_code = `MEM_CODE_OK;
    i_mem_res_rd_data = mem[o_mem_req_addr[9:2]];
  end

  // Completes accesses, counts stall cycles and logs finished writes.
  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
    if (!resetn) begin
      wait_left <= stall;
    end else if (o_busy) begin
      if (wait_left != 0) begin
        wait_left <= wait_left - 1;
      end else begin
        wait_left <= stall;
        if (o_mem_req_wr_en && i_mem_res_code == `MEM_CODE_OK) begin
          mem[o_mem_req_addr[9:2]] <= o_mem_req_wr_data;
          obs_q.push_back({o_mem_req_addr, o_mem_req_wr_data});
        end
      end
    end else begin
      wait_left <= stall;
    end
  end

  // ---------------- scoreboard / checking ----------------
  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit busy_seen, wr_seen;
  logic                   prev_busy = 1'b0;
  logic [`MEM_CODE_W-1:0] prev_code = '0;
  logic [31:0]            prev_addr = '0, prev_data = '0;
  logic                   prev_wr_en = 1'b0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, check stalls and drain writes.
  task automatic tick();
    logic [63:0] o, e;
    @(negedge clk);
    if (o_done) done_cnt++;
    if (o_busy) busy_seen = 1'b1;
    if (o_mem_req_wr_en) wr_seen = 1'b1;
    if (o_busy && prev_busy && prev_code == `MEM_CODE_PENDING) begin
      check("stall_addr",  72'(o_mem_req_addr),    72'(prev_addr));
      check("stall_wr_en", 72'(o_mem_req_wr_en),   72'(prev_wr_en));
      check("stall_data",  72'(o_mem_req_wr_data), 72'(prev_data));
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write: got %0h expected none", o);
      end else begin
        e = exp_q.pop_front();
        check("write", 72'(o), 72'(e));
      end
    end
    prev_busy  = o_busy;
    prev_code  = i_mem_res_code;
    prev_addr  = o_mem_req_addr;
    prev_data  = o_mem_req_wr_data;
    prev_wr_en = o_mem_req_wr_en;
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = addr[9:2];
    load_data = data;
    model_mem[addr[9:2]] = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) poke(base + 32'(4 * k), $urandom);
  endtask

  // Reference copy: ascending read-then-write, stopping at the first
  // access beyond the responder limit.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, output bit faulted, output logic [31:0] faddr);
    logic [31:0] r, w, v;
    faulted = 1'b0;
    faddr   = '0;
    for (int k = 0; k < len && !faulted; k++) begin
      r = src + 32'(4 * k);
      w = dst + 32'(4 * k);
      if (r > limit) begin
        faulted = 1'b1;
        faddr   = r;
      end else if (w > limit) begin
        faulted = 1'b1;
        faddr   = w;
      end else begin
        v = model_mem[r[9:2]];
        model_mem[w[9:2]] = v;
        exp_q.push_back({w, v});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},     72'(o_busy),            72'(0));
    check({tag, "_done"},     72'(o_done),            72'(0));
    check({tag, "_error"},    72'(o_error),           72'(0));
    check({tag, "_err_addr"}, 72'(o_err_addr),        72'(0));
    check({tag, "_addr"},     72'(o_mem_req_addr),    72'(0));
    check({tag, "_wr_data"},  72'(o_mem_req_wr_data), 72'(0));
    check({tag, "_wr_en"},    72'(o_mem_req_wr_en),   72'(0));
    check({tag, "_count"},    72'(o_mem_req_count),   72'(`MEM_COUNT_WORD));
  endtask

  task automatic check_mem(input logic [31:0] addr);
    check("readback", 72'(mem[addr[9:2]]), 72'(model_mem[addr[9:2]]));
  endtask

  // Start a copy and follow it to completion or fault. With intf set, a
  // second start with other operands is pulsed mid-transfer.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input bit intf);
    bit faulted;
    logic [31:0] faddr;
    int idx, d0;
    model_copy(src, dst, int'(len), faulted, faddr);
    d0 = done_cnt;
    busy_seen = 1'b0;
    wr_seen = 1'b0;
    i_src_addr = src;
    i_dst_addr = dst;
    i_len = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    idx = 1;
    while (!o_done && !(busy_seen && !o_busy) && idx < BUDGET) begin
      i_start = intf && idx == 2;
      if (i_start) begin
        i_src_addr = 32'h300;
        i_dst_addr = 32'h340;
        i_len = 16'd5;
      end
      tick();
      idx++;
    end
    i_start = 1'b0;
    check("no_timeout", 72'(idx < BUDGET), 72'(1));
    if (!faulted) check("latency", 72'(idx), 72'(2 * int'(len) * (stall + 1) + 1));
    check("error", 72'(o_error), 72'(faulted));
    if (faulted) check("err_addr", 72'(o_err_addr), 72'(faddr));
    check("busy_seen", 72'(busy_seen), 72'(len != 0));
    if (len == 0) check("wr_seen", 72'(wr_seen), 72'(0));
    tick();
    check("done_pulses", 72'(done_cnt - d0), 72'(faulted ? 0 : 1));
    check("busy_after", 72'(o_busy), 72'(0));
    check("sb_empty", 72'(exp_q.size()), 72'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    int d0;
    resetn = 1'b0;
    i_start = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_len = '0;
    stall = 0;
    limit = 32'h3FC;
    load_en = 1'b0;
    load_idx = '0;
    load_data = '0;
    for (int k = 0; k < 256; k++) model_mem[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Clear the memory while held in reset so every word is defined.
    for (int k = 0; k < 256; k++) poke(32'(4 * k), 32'h0);
    resetn = 1'b1;
    tick();

    // Single word copy from preloaded memory.
    poke(32'h0, 32'hA5A5A5A5);
    poke(32'h4, 32'h12345678);
    run_copy(32'h0, 32'h8, 16'd1, 1'b0);
    check("word8", 72'(mem[2]), 72'(32'hA5A5A5A5));

    // Empty copy.
    run_copy(32'h10, 32'h200, 16'd0, 1'b0);

    // Two words with three stall cycles on every access.
    stall = 3;
    tick();
    run_copy(32'h0, 32'h20, 16'd2, 1'b0);
    check("word20", 72'(mem[8]), 72'(32'hA5A5A5A5));
    check("word24", 72'(mem[9]), 72'(32'h12345678));
    stall = 0;
    tick();

    // Fault on the second write once the responder only covers 0..8.
    limit = 32'h8;
    run_copy(32'h0, 32'h8, 16'd2, 1'b0);
    limit = 32'h3FC;
    run_copy(32'h0, 32'h30, 16'd1, 1'b0);

    // Start pulsed mid-transfer is ignored.
    fill(32'h40, 3);
    run_copy(32'h40, 32'h80, 16'd3, 1'b1);
    for (int k = 0; k < 3; k++) check_mem(32'h80 + 32'(4 * k));
    check_mem(32'h340);

    // Overlapping forward copy replicates the first word.
    fill(32'h60, 3);
    run_copy(32'h60, 32'h64, 16'd3, 1'b0);
    for (int k = 0; k < 4; k++) check_mem(32'h60 + 32'(4 * k));

    // Reset during the second write of a four-word copy.
    fill(32'h100, 4);
    begin
      bit f;
      logic [31:0] fa;
      model_copy(32'h100, 32'h180, 1, f, fa);
    end
    i_src_addr = 32'h100;
    i_dst_addr = 32'h180;
    i_len = 16'd4;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || !o_mem_req_wr_en) && guard < BUDGET) begin
      tick();
      guard++;
    end
    check("reach_second_write", 72'(guard < BUDGET), 72'(1));
    resetn = 1'b0;
    d0 = done_cnt;
    tick();
    check_reset_outputs("midreset");
    resetn = 1'b1;
    busy_seen = 1'b0;
    wr_seen = 1'b0;
    repeat (6) tick();
    check("midreset_busy_seen", 72'(busy_seen), 72'(0));
    check("midreset_wr_seen", 72'(wr_seen), 72'(0));
    check("midreset_done", 72'(done_cnt - d0), 72'(0));
    check("midreset_sb_empty", 72'(exp_q.size()), 72'(0));
    check_mem(32'h180);
    check_mem(32'h184);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
